push_button_debouncer: RTL and testbench

PUSH_BUTTON_DEBOUNCER -- requirements
Module: push_button_debouncer

---
 rtl/push_button_debouncer.sv | 190 +++++++++++++++++++
 tb/tb_push_button_debouncer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/push_button_debouncer.sv
// Multi-channel push-button debouncer: per-channel synchronizer, four-state debounce FSM,
// registered level/rise/fall/toggle outputs and a two-flop synchronized reset release.
module push_button_debouncer #(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_toggle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES <= 2);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  logic [1:0] rst_pipe;
  logic       run;

  // Assertion is immediate; release ripples through two flops so every channel starts together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign run = rst_pipe[1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_i;
    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   accept_rise;
    logic                   accept_fall;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   toggle_q;
    logic                   toggle_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_ff <= '0;
      end else if (!run) begin
        sync_ff <= '0;
      end else begin
        sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_raw[i]};
      end
    end

    assign sync_i = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE_LOW;
        cnt_q   <= '0;
      end else if (!run) begin
        state_q <= IDLE_LOW;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // The sample that leaves an IDLE state counts as the first stable cycle of the candidate level.
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept_rise = 1'b0;
      accept_fall = 1'b0;
      case (state_q)
        IDLE_LOW: begin
          if (sync_i) begin
            if (SINGLE_SAMPLE) begin
              accept_rise = 1'b1;
              state_d     = IDLE_HIGH;
              cnt_d       = '0;
            end else begin
              state_d = CHECK_HIGH;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHECK_HIGH: begin
          if (!sync_i) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q >= CNT_LAST) begin
            accept_rise = 1'b1;
            state_d     = IDLE_HIGH;
            cnt_d       = '0;
          end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!sync_i) begin
            if (SINGLE_SAMPLE) begin
              accept_fall = 1'b1;
              state_d     = IDLE_LOW;
              cnt_d       = '0;
            end else begin
              state_d = CHECK_LOW;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHECK_LOW: begin
          if (sync_i) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q >= CNT_LAST) begin
            accept_fall = 1'b1;
            state_d     = IDLE_LOW;
            cnt_d       = '0;
          end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end

    always_comb begin
      level_d  = level_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      toggle_d = toggle_q;
      if (accept_rise) begin
        level_d  = 1'b1;
        rise_d   = 1'b1;
        toggle_d = ~toggle_q;
      end
      if (accept_fall) begin
        level_d = 1'b0;
        fall_d  = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        toggle_q <= 1'b0;
      end else if (!run) begin
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        toggle_q <= 1'b0;
      end else begin
        level_q  <= level_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        toggle_q <= toggle_d;
      end
    end

    assign btn_level[i]  = level_q;
    assign btn_rise[i]   = rise_q;
    assign btn_fall[i]   = fall_q;
    assign btn_toggle[i] = toggle_q;
  end

endmodule

// File: tb/tb_push_button_debouncer.sv
// Bench for push_button_debouncer: directed scenarios plus random bouncing, all compared
// every cycle against a sliding-window reference model of the debounce rule.
module tb_push_button_debouncer;

  localparam int CH  = 2;
  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int WIN = DC - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] btn_raw = '0;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_rise;
  logic [CH-1:0] btn_fall;
  logic [CH-1:0] btn_toggle;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;

  logic [CH-1:0] m_level;
  logic [CH-1:0] m_rise;
  logic [CH-1:0] m_fall;
  logic [CH-1:0] m_toggle;
  int            rel_edges;
  logic [CH-1:0] raw_hist[$];
  logic [CH-1:0] sync_hist[$];

  always #5 clk = ~clk;

  push_button_debouncer #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_toggle(btn_toggle)
  );

  function automatic void modelReset();
    m_level   = '0;
    m_rise    = '0;
    m_fall    = '0;
    m_toggle  = '0;
    rel_edges = 0;
    raw_hist.delete();
    sync_hist.delete();
  endfunction

  // A channel flips when its last WIN synchronized samples all disagree with the accepted level.
  task automatic modelStep();
    logic [CH-1:0] s;
    bit            all_opp;
    if (!rst_n) begin
      modelReset();
      return;
    end
    m_rise = '0;
    m_fall = '0;
    if (rel_edges < 2) begin
      rel_edges++;
      return;
    end
    raw_hist.push_back(btn_raw);
    s = (raw_hist.size() > SS) ? raw_hist[raw_hist.size() - 1 - SS] : '0;
    sync_hist.push_back(s);
    for (int c = 0; c < CH; c++) begin
      if (sync_hist.size() >= WIN) begin
        all_opp = 1'b1;
        for (int k = 0; k < WIN; k++) begin
          if (sync_hist[sync_hist.size() - 1 - k][c] == m_level[c]) all_opp = 1'b0;
        end
        if (all_opp) begin
          if (m_level[c] == 1'b0) begin
            m_level[c]  = 1'b1;
            m_rise[c]   = 1'b1;
            m_toggle[c] = ~m_toggle[c];
          end else begin
            m_level[c] = 1'b0;
            m_fall[c]  = 1'b1;
          end
        end
      end
    end
    if (raw_hist.size() > 16) void'(raw_hist.pop_front());
    if (sync_hist.size() > 16) void'(sync_hist.pop_front());
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_level"},  16'(btn_level),  16'(m_level));
    checkOutput({tag, "_rise"},   16'(btn_rise),   16'(m_rise));
    checkOutput({tag, "_fall"},   16'(btn_fall),   16'(m_fall));
    checkOutput({tag, "_toggle"}, 16'(btn_toggle), 16'(m_toggle));
    checkOutput({tag, "_excl"},   16'(btn_rise & btn_fall), 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkAll("cycle");
    rise_cnt += $countones(btn_rise);
    fall_cnt += $countones(btn_fall);
  endtask

  task automatic applyStimulus(input logic [CH-1:0] raw, input int n);
    btn_raw = raw;
    repeat (n) tick();
  endtask

  task automatic doReset();
    btn_raw = '0;
    rst_n   = 1'b0;
    modelReset();
    #1;
    checkAll("reset_async");
    applyStimulus('0, 2);
    rst_n = 1'b1;
    applyStimulus('0, 2);
    rise_cnt = 0;
    fall_cnt = 0;
  endtask

  initial begin
    #3;
    doReset();
    checkOutput("reset_level", 16'(btn_level), 16'h0);
    checkOutput("reset_toggle", 16'(btn_toggle), 16'h0);

    $display("[TB] clean press");
    applyStimulus(2'b01, 4);
    checkOutput("press_edge4_level", 16'(btn_level), 16'h0);
    applyStimulus(2'b01, 1);
    checkOutput("press_edge5_level", 16'(btn_level), 16'h1);
    checkOutput("press_edge5_rise", 16'(btn_rise), 16'h1);
    checkOutput("press_edge5_toggle", 16'(btn_toggle), 16'h1);
    applyStimulus(2'b01, 1);
    checkOutput("press_edge6_rise", 16'(btn_rise), 16'h0);
    checkOutput("press_edge6_level", 16'(btn_level), 16'h1);

    $display("[TB] bounce reject");
    doReset();
    applyStimulus(2'b01, 2);
    applyStimulus(2'b00, 1);
    applyStimulus(2'b01, 2);
    applyStimulus(2'b00, 10);
    checkOutput("bounce_level", 16'(btn_level), 16'h0);
    checkOutput("bounce_toggle", 16'(btn_toggle), 16'h0);
    checkOutput("bounce_rises", 16'(rise_cnt), 16'h0);

    $display("[TB] release and toggle");
    doReset();
    applyStimulus(2'b01, 10);
    checkOutput("rt_press1_level", 16'(btn_level), 16'h1);
    checkOutput("rt_press1_toggle", 16'(btn_toggle), 16'h1);
    applyStimulus(2'b00, 10);
    checkOutput("rt_release_level", 16'(btn_level), 16'h0);
    checkOutput("rt_release_toggle", 16'(btn_toggle), 16'h1);
    applyStimulus(2'b01, 10);
    checkOutput("rt_press2_level", 16'(btn_level), 16'h1);
    checkOutput("rt_press2_toggle", 16'(btn_toggle), 16'h0);
    checkOutput("rt_rises", 16'(rise_cnt), 16'h2);
    checkOutput("rt_falls", 16'(fall_cnt), 16'h1);

    $display("[TB] simultaneous press");
    doReset();
    applyStimulus(2'b11, 4);
    checkOutput("sim_edge4_rise", 16'(btn_rise), 16'h0);
    applyStimulus(2'b11, 1);
    checkOutput("sim_edge5_rise", 16'(btn_rise), 16'h3);
    checkOutput("sim_edge5_level", 16'(btn_level), 16'h3);

    $display("[TB] reset mid-check");
    doReset();
    applyStimulus(2'b10, 3);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rmc_async_level", 16'(btn_level), 16'h0);
    applyStimulus(2'b10, 2);
    rst_n = 1'b1;
    applyStimulus(2'b10, 2);
    rise_cnt = 0;
    applyStimulus(2'b10, 4);
    checkOutput("rmc_edge4_level", 16'(btn_level), 16'h0);
    applyStimulus(2'b10, 1);
    checkOutput("rmc_edge5_rise", 16'(btn_rise), 16'h2);
    checkOutput("rmc_edge5_level", 16'(btn_level), 16'h2);
    applyStimulus(2'b10, 3);
    checkOutput("rmc_rises", 16'(rise_cnt), 16'h1);

    $display("[TB] saturation hold");
    doReset();
    applyStimulus(2'b01, 1000);
    checkOutput("sat_rises", 16'(rise_cnt), 16'h1);
    checkOutput("sat_level", 16'(btn_level), 16'h1);

    $display("[TB] random bouncing");
    doReset();
    for (int seg = 0; seg < 120; seg++) begin
      logic [CH-1:0] r;
      int            hold;
      r    = CH'($urandom_range(0, 3));
      hold = (seg % 10 == 9) ? 12 : int'($urandom_range(1, 6));
      applyStimulus(r, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
